ft245_ctrl: RTL and testbench

Sequencing controller for the FT245-style parallel USB FIFO bus: it owns the shared 8-bit data bus, the rd/wr strobes and the output enable, and arbitrates between the receive path (chip to SoC) and the transmit path (SoC to chip). It sits between the pad-level bus logic in the top level and the SoC's byte streams. The flag inputs arrive already synchronized, and the top level inverts the strobes.

---
 rtl/ft245_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ft245_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_ctrl.sv
// Sequencing controller for an FT245-style parallel USB FIFO bus: times rd/wr strobes and
// output enable, and arbitrates receive vs transmit. Define FT245_CTRL_FAIR_EN for round-robin.
module ft245_ctrl #(
  parameter int unsigned RD_CYCLES  = 4,
  parameter int unsigned WR_SETUP   = 1,
  parameter int unsigned WR_CYCLES  = 3,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxf_n,
  input  logic       txe_n,
  input  logic [7:0] bus_rdata,
  output logic [7:0] bus_wdata,
  output logic       bus_oe,
  output logic       bus_rd,
  output logic       bus_wr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_GAP
  } state_t;

  // Counter load values: each state lasts (load + 1) cycles.
  localparam logic [3:0] RD_LOAD  = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WS_LOAD  = 4'(WR_SETUP - 1);
  localparam logic [3:0] WC_LOAD  = 4'(WR_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       rd_nxt, wr_nxt, oe_nxt, capture;
  logic       rx_elig, tx_elig, grant_rx, grant_tx;

  assign rx_elig = !rxf_n && !rx_valid;
  assign tx_elig = !txe_n && tx_valid;

`ifdef FT245_CTRL_FAIR_EN
  logic last_tx;  // 1 = most recent transfer was a write
  assign grant_rx = (state == S_IDLE) && rx_elig && (!tx_elig || last_tx);
`else
  assign grant_rx = (state == S_IDLE) && rx_elig;
`endif
  assign grant_tx = (state == S_IDLE) && tx_elig && !grant_rx;

  // Gated by rst_n so no byte is reported as accepted while the controller is held in reset.
  assign tx_ready = rst_n && grant_tx;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_rx) begin
          state_nxt = S_RD;
          cnt_nxt   = RD_LOAD;
          rd_nxt    = 1'b1;
        end else if (grant_tx) begin
          state_nxt = S_WR_SETUP;
          cnt_nxt   = WS_LOAD;
          oe_nxt    = 1'b1;
        end
      end
      S_RD: begin
        if (cnt == 4'd0) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LOAD;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
          rd_nxt  = 1'b1;
        end
      end
      S_WR_SETUP: begin
        oe_nxt = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = S_WR_PULSE;
          cnt_nxt   = WC_LOAD;
          wr_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_WR_PULSE: begin
        oe_nxt = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = S_WR_HOLD;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          wr_nxt  = 1'b1;
        end
      end
      S_WR_HOLD: begin
        state_nxt = S_GAP;
        cnt_nxt   = GAP_LOAD;
      end
      S_GAP: begin
        if (cnt == 4'd0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_oe    <= 1'b0;
      bus_wdata <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bus_rd <= rd_nxt;
      bus_wr <= wr_nxt;
      bus_oe <= oe_nxt;
      if (grant_tx) bus_wdata <= tx_data;
      if (capture) begin
        rx_data  <= bus_rdata;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef FT245_CTRL_FAIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_tx <= 1'b1;
    else if (grant_rx) last_tx <= 1'b0;
    else if (grant_tx) last_tx <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ft245_ctrl.sv
// Self-checking bench for ft245_ctrl: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a transaction-timeline model.
module tb_ft245_ctrl;

  localparam int RD  = 4;
  localparam int WS  = 1;
  localparam int WC  = 3;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxf_n = 1'b1;
  logic       txe_n = 1'b1;
  logic [7:0] bus_rdata = 8'h00;
  logic [7:0] bus_wdata;
  logic       bus_oe, bus_rd, bus_wr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  ft245_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rxf_n(rxf_n), .txe_n(txe_n),
    .bus_rdata(bus_rdata), .bus_wdata(bus_wdata), .bus_oe(bus_oe),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each transfer is a timeline anchored at its grant cycle.
  int         cyc = 0;
  int         m_idle_at = 0;
  int         m_t0 = 0;
  bit         m_read = 1'b0;
  logic       m_rx_valid = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  bit         m_last_tx = 1'b1;

  always @(negedge clk) begin
    int   k;
    bit   busy, rx_e, tx_e, g_rx, g_tx;
    logic e_rd, e_wr, e_oe;
    cyc++;
    if (!rst_n) begin
      m_idle_at  = cyc + 1;
      m_rx_valid = 1'b0;
      m_rx_data  = 8'h00;
      m_wdata    = 8'h00;
      m_last_tx  = 1'b1;
      check("rst_rd", bus_rd, 8'd0);
      check("rst_wr", bus_wr, 8'd0);
      check("rst_oe", bus_oe, 8'd0);
      check("rst_tx_ready", tx_ready, 8'd0);
      check("rst_rx_valid", rx_valid, 8'd0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_wdata", bus_wdata, 8'h00);
    end else begin
      busy = (cyc < m_idle_at);
      k    = cyc - m_t0;
      e_rd = 1'b0; e_wr = 1'b0; e_oe = 1'b0;
      g_rx = 1'b0; g_tx = 1'b0;
      if (busy) begin
        if (m_read) begin
          e_rd = (k >= 1 && k <= RD);
        end else begin
          e_oe = (k >= 1 && k <= WS + WC + 1);
          e_wr = (k >= WS + 1 && k <= WS + WC);
        end
      end else begin
        rx_e = !rxf_n && !m_rx_valid;
        tx_e = !txe_n && tx_valid;
`ifdef FT245_CTRL_FAIR_EN
        g_rx = rx_e && (!tx_e || m_last_tx);
`else
        g_rx = rx_e;
`endif
        g_tx = tx_e && !g_rx;
      end
      check("m_rd", bus_rd, e_rd);
      check("m_wr", bus_wr, e_wr);
      check("m_oe", bus_oe, e_oe);
      check("m_tx_ready", tx_ready, g_tx);
      check("m_wdata", bus_wdata, m_wdata);
      check("m_rx_valid", rx_valid, m_rx_valid);
      check("m_rx_data", rx_data, m_rx_data);
      check("rd_oe_excl", bus_rd & bus_oe, 8'd0);
      check("rd_wr_excl", bus_rd & bus_wr, 8'd0);
      if (m_rx_valid && rx_ready) m_rx_valid = 1'b0;
      if (busy && m_read && k == RD) begin
        m_rx_valid = 1'b1;
        m_rx_data  = bus_rdata;
      end
      if (g_rx) begin
        m_read = 1'b1; m_t0 = cyc; m_idle_at = cyc + RD + GAP + 1; m_last_tx = 1'b0;
      end
      if (g_tx) begin
        m_read = 1'b0; m_t0 = cyc; m_idle_at = cyc + WS + WC + GAP + 2; m_last_tx = 1'b1;
        m_wdata = tx_data;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) next_cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] order;
    logic [3:0] exp_order;
    int         n_seen;
    logic       prev_rd, prev_oe;

    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read; no second read while rx_valid is set
    rxf_n = 1'b0; rx_ready = 1'b0; bus_rdata = 8'hA5;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("read_rd", bus_rd, (k >= 1 && k <= 4));
      if (k == 5) begin
        check("read_rx_valid", rx_valid, 8'd1);
        check("read_rx_data", rx_data, 8'hA5);
      end
      next_cyc();
    end
    bus_rdata = 8'h5A;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_reread", bus_rd, 8'd0);
      next_cyc();
    end
    rxf_n = 1'b1; rx_ready = 1'b1;
    next_cyc();
    rx_ready = 1'b0;
    @(negedge clk);
    check("read_drained", rx_valid, 8'd0);
    next_cyc();

    // Single write
    tx_data = 8'h3C; tx_valid = 1'b1; txe_n = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check("write_tx_ready", tx_ready, (k == 0));
      check("write_oe", bus_oe, (k >= 1 && k <= 5));
      check("write_wr", bus_wr, (k >= 2 && k <= 4));
      check("write_rd", bus_rd, 8'd0);
      if (k >= 1) check("write_wdata", bus_wdata, 8'h3C);
      next_cyc();
      if (k == 0) begin
        tx_valid = 1'b0; tx_data = 8'hFF;
      end
    end
    txe_n = 1'b1;
    wait_cyc(5);

    // Back-pressure, then release
    tx_valid = 1'b1; tx_data = 8'h81;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bp_tx_ready", tx_ready, 8'd0);
      check("bp_oe", bus_oe, 8'd0);
      next_cyc();
    end
    txe_n = 1'b0;
    @(negedge clk);
    check("bp_release", tx_ready, 8'd1);
    next_cyc();
    tx_valid = 1'b0;
    wait_cyc(12);

    // Reset during WR_PULSE
    tx_valid = 1'b1; tx_data = 8'h42;
    @(negedge clk);
    check("rstw_tx_ready", tx_ready, 8'd1);
    next_cyc();
    tx_valid = 1'b0;
    wait_cyc(2);
    @(negedge clk);
    check("rstw_wr_before", bus_wr, 8'd1);
    #1 rst_n = 1'b0; tx_valid = 1'b1;
    #1;
    check("rstw_wr_async", bus_wr, 8'd0);
    check("rstw_oe_async", bus_oe, 8'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstw_wdata", bus_wdata, 8'h00);
    check("rstw_rx_data", rx_data, 8'h00);
    check("rstw_tx_ready", tx_ready, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstw_idle_accept", tx_ready, 8'd1);
    check("rstw_oe_idle", bus_oe, 8'd0);
    next_cyc();
    tx_valid = 1'b0; txe_n = 1'b1;
    wait_cyc(12);

    // rxf_n rises mid-read
    rxf_n = 1'b0; rx_ready = 1'b0; bus_rdata = 8'h3E;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("drop_rd", bus_rd, (k >= 1 && k <= 4));
      if (k == 5) begin
        check("drop_rx_valid", rx_valid, 8'd1);
        check("drop_rx_data", rx_data, 8'h3E);
      end
      next_cyc();
      if (k == 1) rxf_n = 1'b1;
    end
    rx_ready = 1'b1;
    wait_cyc(6);
    rx_ready = 1'b0;

    // Contention from reset: order of the first four transfers
    do_reset();
    rxf_n = 1'b0; txe_n = 1'b0; tx_valid = 1'b1; rx_ready = 1'b1;
    order = 4'b0000; n_seen = 0; prev_rd = 1'b0; prev_oe = 1'b0;
    for (int k = 0; k < 60 && n_seen < 4; k++) begin
      @(negedge clk);
      if (bus_rd && !prev_rd) begin
        order[n_seen] = 1'b0; n_seen++;
      end else if (bus_oe && !prev_oe) begin
        order[n_seen] = 1'b1; n_seen++;
      end
      prev_rd = bus_rd; prev_oe = bus_oe;
      next_cyc();
      tx_data = 8'($urandom);
    end
`ifdef FT245_CTRL_FAIR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    check("contention_count", 8'(n_seen), 8'd4);
    check("contention_order", {4'd0, order}, {4'd0, exp_order});
    rxf_n = 1'b1; txe_n = 1'b1; tx_valid = 1'b0;
    wait_cyc(15);
    rx_ready = 1'b0;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rxf_n     = ($urandom_range(0, 3) == 0);
      txe_n     = ($urandom_range(0, 2) == 0);
      tx_valid  = 1'($urandom_range(0, 1));
      tx_data   = 8'($urandom);
      rx_ready  = ($urandom_range(0, 3) == 0);
      bus_rdata = 8'($urandom);
      next_cyc();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
